multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: Moore FSM sequencing fetch/decode/execute
// for lw, sw, R-type, beq, addi and j, flagging unsupported op/funct.
module multicycle_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       mem2reg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alu_control,
    output logic [3:0] state,
    output logic       illegal
);

    // state   | meaning
    // FETCH   | read instruction, PC += 4
    // DECODE  | dispatch on op, precompute branch target
    // MEMADR  | base + offset for lw/sw
    // MEMRD   | read data memory
    // MEMWB   | write loaded word to rt
    // MEMWR   | write store data to memory
    // EXECUTE | R-type ALU operation
    // ALUWB   | write ALU result to rd
    // BRANCH  | compare, take branch if zero
    // ADDIEX  | rs + sign_imm
    // ADDIWB  | write sum to rt
    // JUMP    | load jump target
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       op_ok;
    logic [2:0] alu_held;

    always_comb begin
        funct_alu = ALU_ADD;
        funct_ok  = 1'b1;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
            default:                                       op_ok = 1'b0;
        endcase
    end

    // alu_held keeps the EXECUTE operation visible through ALUWB without
    // re-reading funct, which may change once EXECUTE has passed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_FETCH;
            alu_held <= ALU_ADD;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state_q <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state_q <= S_MEMWB;
                S_MEMWB:   state_q <= S_FETCH;
                S_MEMWR:   state_q <= S_FETCH;
                S_EXECUTE: begin
                    alu_held <= funct_alu;
                    state_q  <= funct_ok ? S_ALUWB : S_FETCH;
                end
                S_ALUWB:   state_q <= S_FETCH;
                S_BRANCH:  state_q <= S_FETCH;
                S_ADDIEX:  state_q <= S_ADDIWB;
                S_ADDIWB:  state_q <= S_FETCH;
                S_JUMP:    state_q <= S_FETCH;
                default:   state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pcen        = 1'b0;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        mem2reg     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcen    = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = ~op_ok;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem2reg  = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca     = 1'b1;
                alu_control = funct_alu;
                illegal     = ~funct_ok;
            end
            S_ALUWB: begin
                regdst      = 1'b1;
                regwrite    = 1'b1;
                alu_control = alu_held;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                alu_control = ALU_SUB;
                pcsrc       = 2'b01;
                pcen        = zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        // Reset is synchronous, so the state may still be mid-instruction
        // during the reset cycle; suppress every write it would cause.
        if (RST) begin
            pcen     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state = state_q;

endmodule
